multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 22 ++
 rtl/multicycle_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Memory-side handshake of the multicycle controller: request, direction,
// address select and the acknowledge returned by memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// sticky traps for illegal opcodes and memory-wait timeouts.
module multicycle_control #(
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [6:0]           opcode,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 branch,
  output logic                 jump,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [2:0]           state,
  output logic                 retire,
  output logic                 illegal,
  output logic                 timeout
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [6:0] op);
    case (op)
      OP_BRANCH: alu_code = 3'b001;
      OP_LOAD:   alu_code = 3'b010;
      OP_STORE:  alu_code = 3'b011;
      OP_OPIMM:  alu_code = 3'b100;
      OP_OP:     alu_code = 3'b101;
      OP_AUIPC:  alu_code = 3'b110;
      default:   alu_code = 3'b000;
    endcase
  endfunction

  logic [2:0]       state_r, state_nx_s;
  logic [6:0]       op_q_r, op_q_nx_s;
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_nx_s;
  logic             illegal_r, illegal_nx_s;
  logic             timeout_r, timeout_nx_s;
  logic             is_load_s, is_store_s, is_branch_s, is_jal_s;
  logic [2:0]       alu_code_s;

  assign is_load_s   = (op_q_r == OP_LOAD);
  assign is_store_s  = (op_q_r == OP_STORE);
  assign is_branch_s = (op_q_r == OP_BRANCH);
  assign is_jal_s    = (op_q_r == OP_JAL);
  assign alu_code_s  = alu_code(op_q_r);

  // Next-state logic; every entry into FETCH or MEM restarts the wait counter.
  always_comb begin
    state_nx_s    = state_r;
    op_q_nx_s     = op_q_r;
    wait_cnt_nx_s = wait_cnt_r;
    illegal_nx_s  = illegal_r;
    timeout_nx_s  = timeout_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s    = S_FETCH;
          wait_cnt_nx_s = CNT_ZERO;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_FETCH, S_MEM: begin
        if (mem.mem_ready) begin
          if (state_r == S_FETCH) begin
            state_nx_s = S_DECODE;
          end else if (is_store_s) begin
            state_nx_s    = S_FETCH;
            wait_cnt_nx_s = CNT_ZERO;
          end else begin
            state_nx_s = S_WB;
          end
        end else if (wait_cnt_r == WAIT_LIMIT) begin
          state_nx_s   = S_TRAP;
          timeout_nx_s = 1'b1;
        end else begin
          wait_cnt_nx_s = wait_cnt_r + CNT_ONE;
        end
      end
      S_DECODE: begin
        op_q_nx_s = opcode;
        if (is_legal(opcode)) begin
          state_nx_s = S_EXEC;
        end else begin
          state_nx_s   = S_TRAP;
          illegal_nx_s = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) begin
          state_nx_s    = S_MEM;
          wait_cnt_nx_s = CNT_ZERO;
        end else if (is_branch_s) begin
          state_nx_s    = S_FETCH;
          wait_cnt_nx_s = CNT_ZERO;
        end else begin
          state_nx_s = S_WB;
        end
      end
      S_WB: begin
        if (start) begin
          state_nx_s    = S_FETCH;
          wait_cnt_nx_s = CNT_ZERO;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_TRAP:  state_nx_s = S_TRAP;
      default: state_nx_s = S_TRAP;
    endcase
  end

  // State, latched opcode, wait counter and sticky trap causes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      op_q_r     <= 7'd0;
      wait_cnt_r <= CNT_ZERO;
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      op_q_r     <= op_q_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
      illegal_r  <= illegal_nx_s;
      timeout_r  <= timeout_nx_s;
    end
  end

  // Datapath controls depend only on state, op_q and mem_ready.
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    retire      = 1'b0;
    alu_op      = ALUOP_W'(3'b000);
    case (state_r)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
      end
      S_EXEC: begin
        alu_src  = !(is_branch_s || (op_q_r == OP_OP));
        alu_op   = ALUOP_W'(alu_code_s);
        branch   = is_branch_s;
        pc_write = is_branch_s;
        retire   = is_branch_s;
        jump     = is_jal_s;
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = is_store_s;
        alu_op      = ALUOP_W'(alu_code_s);
        pc_write    = is_store_s && mem.mem_ready;
        retire      = is_store_s && mem.mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load_s;
        jump       = is_jal_s;
        pc_write   = 1'b1;
        retire     = 1'b1;
        alu_op     = ALUOP_W'(alu_code_s);
      end
      default: begin
        alu_op = ALUOP_W'(3'b000);
      end
    endcase
  end

  assign state   = state_r;
  assign illegal = illegal_r;
  assign timeout = timeout_r;

endmodule
